score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 194 +++++++++++++++++++
 tb/tb_score_keeper.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Score keeper: three debounced push-buttons drive a saturating 0..511 score.
// Up/down auto-repeat while held, clear resets, and a strobe marks each change.

module score_keeper_debounce #(
    parameter int DEB_N = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = (DEB_N < 1) ? 1 : $clog2(DEB_N + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // The counter sits at DEB_N for one more disagreeing cycle before the flip,
    // so a held level reaches the debounced output DEB_N+2 edges after first sampling.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
            // which is what makes the two sync stages a real two-stage chain.
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_N)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module score_keeper_repeat #(
    parameter int REP_DELAY = 50000000,
    parameter int REP_RATE  = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic press,
    output logic step
);
    localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int CNT_W   = (REP_MAX < 2) ? 1 : $clog2(REP_MAX);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REP_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr, cnt_inc;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: assigning a default before the case means no path leaves the
        // signal unassigned, so no latch can be inferred.
        state_nxt = state;
        case (state)
            S_IDLE:   if (press) state_nxt = S_WAIT;
            S_WAIT:   if (!level) state_nxt = S_IDLE;
                      else if (cnt == DELAY_LAST) state_nxt = S_REPEAT;
            S_REPEAT: if (!level) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // A release is checked before the counter so stepping stops as soon as the level drops.
    always_comb begin
        step    = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                step    = press;
            end
            S_WAIT: begin
                if (!level) begin
                    cnt_clr = 1'b1;
                end else if (cnt == DELAY_LAST) begin
                    step    = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_REPEAT: begin
                if (!level) begin
                    cnt_clr = 1'b1;
                end else if (cnt == RATE_LAST) begin
                    step    = 1'b1;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end
endmodule

module score_keeper #(
    parameter int DEB_N     = 65535,
    parameter int REP_DELAY = 50000000,
    parameter int REP_RATE  = 10000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [8:0] value,
    output logic       changed
);
    localparam logic [8:0] VALUE_MAX = 9'd511;

    logic [2:0] raw_btn, level, level_d, press;
    logic       up_step, dn_step;
    logic [8:0] value_nxt;

    assign raw_btn = {btn_clr, btn_down, btn_up};

    for (genvar i = 0; i < 3; i++) begin : g_deb
        score_keeper_debounce #(.DEB_N(DEB_N)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_btn[i]),
            .level (level[i])
        );
    end

    assign press = level & ~level_d;

    score_keeper_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_up (
        .clk   (clk),
        .rst_n (rst_n),
        .level (level[0]),
        .press (press[0]),
        .step  (up_step)
    );

    score_keeper_repeat #(.REP_DELAY(REP_DELAY), .REP_RATE(REP_RATE)) u_rep_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .level (level[1]),
        .press (press[1]),
        .step  (dn_step)
    );

    // Clear wins; a simultaneous up and down cancel; saturate at both ends.
    always_comb begin
        value_nxt = value;
        if (press[2])
            value_nxt = '0;
        else if (up_step && dn_step)
            value_nxt = value;
        else if (up_step && value != VALUE_MAX)
            value_nxt = value + 9'd1;
        else if (dn_step && value != 9'd0)
            value_nxt = value - 9'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            level_d <= '0;
            value   <= '0;
            changed <= 1'b0;
        end else begin
            level_d <= level;
            value   <= value_nxt;
            changed <= (value_nxt != value);
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with short debounce/repeat times; every
// expected value is written out by hand from the button timeline.

module tb_score_keeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up, btn_down, btn_clr;
    logic [8:0] value;
    logic       changed;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper #(.DEB_N(4), .REP_DELAY(20), .REP_RATE(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_clr  (btn_clr),
        .value    (value),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_vc(input string tag, input int exp_v, input logic exp_c);
        check({tag, "_value"}, value, 9'(exp_v));
        check({tag, "_changed"}, 9'(changed), 9'(exp_c));
    endtask

    task automatic quiet(input int n, input int exp_v, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            check_vc($sformatf("%s_%0d", tag, i), exp_v, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_v;
        logic exp_c;

        rst_n = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
        cyc(3);
        check_vc("reset", 0, 1'b0);
        rst_n = 1'b0;
        quiet(5, 0, "idle");

        // Single press: visible exactly 7 edges after the first sampling edge.
        btn_up = 1'b1;
        cyc(7);
        btn_up = 1'b0;
        check_vc("lat_before", 0, 1'b0);
        cyc(1);
        check_vc("lat_step", 1, 1'b1);
        quiet(25, 1, "single");

        btn_up = 1'b1;
        cyc(3);
        btn_up = 1'b0;
        quiet(20, 1, "glitch");

        // Hold up for 60 sampling edges: steps at +7, +27, then every 5 up to +62.
        btn_up = 1'b1;
        for (int k = 0; k < 80; k++) begin
            cyc(1);
            if (k == 59) btn_up = 1'b0;
            exp_v = 1;
            if (k >= 7) exp_v++;
            if (k >= 27) exp_v += 1 + (((k < 62) ? k : 62) - 27) / 5;
            exp_c = (k == 7) || (k >= 27 && k <= 62 && (k - 27) % 5 == 0);
            check_vc($sformatf("hold_%0d", k), exp_v, exp_c);
        end

        // Up and down together cancel; with clear as well, clear wins.
        btn_up = 1'b1; btn_down = 1'b1;
        cyc(7);
        btn_up = 1'b0; btn_down = 1'b0;
        quiet(25, 10, "cancel");

        btn_up = 1'b1; btn_down = 1'b1; btn_clr = 1'b1;
        for (int k = 0; k < 25; k++) begin
            cyc(1);
            if (k == 6) begin
                btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
            end
            check_vc($sformatf("clr_all_%0d", k), (k >= 7) ? 0 : 10, k == 7);
        end

        btn_down = 1'b1;
        cyc(7);
        btn_down = 1'b0;
        quiet(25, 0, "down_at_zero");

        // Climb to the top: value v appears at +27 + 5*(v-2).
        btn_up = 1'b1;
        for (int k = 0; k < 2600; k++) begin
            cyc(1);
            if (k == 2599) btn_up = 1'b0;
            if (k == 2571) check_vc("pre_510", 510, 1'b0);
            if (k == 2572) check_vc("pre_511", 511, 1'b1);
            if (k == 2577) check_vc("pre_sat", 511, 1'b0);
        end
        quiet(25, 511, "top_release");

        btn_up = 1'b1;
        cyc(7);
        btn_up = 1'b0;
        quiet(25, 511, "up_at_max");

        btn_clr = 1'b1;
        cyc(7);
        btn_clr = 1'b0;
        cyc(1);
        check_vc("clr_from_max", 0, 1'b1);
        quiet(20, 0, "after_clr");

        // Climb to 40, releasing right after 39 so the pending step to 40 still lands.
        btn_up = 1'b1;
        for (int k = 0; k < 240; k++) begin
            cyc(1);
            if (k == 212) begin
                btn_up = 1'b0;
                check_vc("climb_39", 39, 1'b1);
            end
            if (k == 217) check_vc("climb_40", 40, 1'b1);
        end
        check_vc("climb_final", 40, 1'b0);

        // Hold down into repeat, then reset while at 30.
        btn_down = 1'b1;
        for (int k = 0; k < 68; k++) begin
            cyc(1);
            if (k == 7)  check_vc("down_39", 39, 1'b1);
            if (k == 27) check_vc("down_38", 38, 1'b1);
        end
        check_vc("down_30", 30, 1'b1);
        rst_n = 1'b1;
        cyc(1);
        check_vc("mid_reset", 0, 1'b0);
        rst_n = 1'b0;
        quiet(40, 0, "held_after_reset");
        btn_down = 1'b0;
        quiet(20, 0, "down_release");

        // A held up button across reset counts as a fresh press afterwards.
        btn_up = 1'b1;
        cyc(10);
        check_vc("pre_reset_up", 1, 1'b0);
        rst_n = 1'b1;
        cyc(1);
        check_vc("reset_up_held", 0, 1'b0);
        rst_n = 1'b0;
        cyc(7);
        check_vc("repress_before", 0, 1'b0);
        cyc(1);
        check_vc("repress_step", 1, 1'b1);
        btn_up = 1'b0;
        quiet(25, 1, "repress_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
